io_read: RTL and testbench

- Read-side counterpart of the I/O write path. Decodes the raw read-operand address, selects and masks the per-port Full bit, and issues a one-cycle read strobe to the addressed input port.
- Captures that port's data and steers either the port word or the RAM read word onto the operand bus toward the ALU, pipeline-aligned.
- Sits between instruction fetch (Stage 1 raw address) and the A/B operand read of each memory bank; one instance per readable bank.

---
 rtl/io_read_if.sv | 41 ++++
 rtl/io_read.sv | 126 ++++++++++++
 tb/tb_io_read.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_read_if.sv
// io_read_if
//   Bundles the operand-read signals of one memory bank's I/O read path.
//   master : instruction fetch / port / RAM side, drives the request and data.
//   slave  : the io_read block, returns the masked Full bit, strobes and word.
// Signals
//   addr_raw          raw operand address (cycle 0)
//   read_enable       operand is really read (cycle 0)
//   EmptyFull         per-port Full flag, 1 = data available
//   IO_ready          thread not annulled (cycle 1)
//   data_IO           packed port words, port p at [p*W +: W]
//   data_RAM          bank read data (cycle 2)
//   EmptyFull_masked  selected Full bit, 1 when not an I/O address (cycle 1)
//   active_IO         one-hot port read strobe (cycle 2)
//   read_is_IO        read serviced by a port (cycle 2)
//   read_data         operand word to the ALU (cycle 3)
interface io_read_if #(
  parameter int WORD_WIDTH         = 36,
  parameter int ADDR_WIDTH         = 10,
  parameter int IO_READ_PORT_COUNT = 4
) ();
  logic [ADDR_WIDTH-1:0]                    addr_raw;
  logic                                     read_enable;
  logic [IO_READ_PORT_COUNT-1:0]            EmptyFull;
  logic                                     IO_ready;
  logic [IO_READ_PORT_COUNT*WORD_WIDTH-1:0] data_IO;
  logic [WORD_WIDTH-1:0]                    data_RAM;
  logic                                     EmptyFull_masked;
  logic [IO_READ_PORT_COUNT-1:0]            active_IO;
  logic                                     read_is_IO;
  logic [WORD_WIDTH-1:0]                    read_data;

  modport master (
    output addr_raw, read_enable, EmptyFull, IO_ready, data_IO, data_RAM,
    input  EmptyFull_masked, active_IO, read_is_IO, read_data
  );

  modport slave (
    input  addr_raw, read_enable, EmptyFull, IO_ready, data_IO, data_RAM,
    output EmptyFull_masked, active_IO, read_is_IO, read_data
  );
endinterface

// File: rtl/io_read.sv
// io_read
//   Read side of the memory-mapped I/O window of one bank. Decodes the raw
//   operand address, reports the addressed port's Full bit, pops the port
//   with a one-cycle strobe and steers either the port word or the RAM word
//   onto the operand bus. Fixed 3-cycle latency, one new address per cycle.
// Ports
//   clock    single clock, all state on posedge
//   reset_n  synchronous active-low reset
//   bus      io_read_if.slave (see interface header for the signal list)
module io_read #(
  parameter int WORD_WIDTH              = 36,
  parameter int ADDR_WIDTH              = 10,
  parameter int IO_READ_PORT_COUNT      = 4,
  parameter int IO_READ_PORT_BASE_ADDR  = 1020,
  parameter int IO_READ_PORT_ADDR_WIDTH = 2
) (
  input  logic   clock,
  input  logic   reset_n,
  io_read_if.slave bus
);

  localparam int IW = IO_READ_PORT_ADDR_WIDTH;

  // Window bounds held one bit wider than the address so BASE+COUNT never wraps.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = (ADDR_WIDTH+1)'(IO_READ_PORT_BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] LIMIT_EXT =
    (ADDR_WIDTH+1)'(IO_READ_PORT_BASE_ADDR + IO_READ_PORT_COUNT);
  // Port index only needs the low bits of (addr - BASE); subtraction mod 2^IW.
  localparam logic [IW-1:0]       BASE_IDX  = IW'(IO_READ_PORT_BASE_ADDR);

  // Cycle 0 decode
  logic [ADDR_WIDTH:0]           addr_ext_s;
  logic                          in_range_s;
  logic                          addr_is_io_s;
  logic [IW-1:0]                 idx_s;
  logic                          masked_s;

  // Cycle 1 registers
  logic                          addr_is_io_r;
  logic [IW-1:0]                 idx_r;
  logic                          ef_masked_r;

  // Cycle 2 registers
  logic                          accept_s;
  logic [IO_READ_PORT_COUNT-1:0] strobe_s;
  logic                          read_is_io_r;
  logic [IO_READ_PORT_COUNT-1:0] active_r;
  logic [IW-1:0]                 idx2_r;

  // Cycle 3 register
  logic [WORD_WIDTH-1:0]         port_word_s;
  logic [WORD_WIDTH-1:0]         read_data_r;

  // Address decode and Full-bit selection for the incoming operand.
  always_comb begin
    addr_ext_s   = {1'b0, bus.addr_raw};
    in_range_s   = (addr_ext_s >= BASE_EXT) && (addr_ext_s < LIMIT_EXT);
    idx_s        = bus.addr_raw[IW-1:0] - BASE_IDX;
    addr_is_io_s = in_range_s & bus.read_enable;
    masked_s     = 1'b1;
    if (addr_is_io_s) begin
      masked_s = bus.EmptyFull[idx_s];
    end else begin
      masked_s = 1'b1;
    end
  end

  // Stage 1: remember whether this operand targets a port, and which one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_is_io_r <= 1'b0;
      idx_r        <= {IW{1'b0}};
      ef_masked_r  <= 1'b0;
    end else begin
      addr_is_io_r <= addr_is_io_s;
      idx_r        <= idx_s;
      ef_masked_r  <= masked_s;
    end
  end

  // Accept the port read only if the thread survived and the port had data.
  always_comb begin
    accept_s = addr_is_io_r & bus.IO_ready & ef_masked_r;
    strobe_s = {IO_READ_PORT_COUNT{1'b0}};
    if (accept_s) begin
      strobe_s[idx_r] = 1'b1;
    end else begin
      strobe_s = {IO_READ_PORT_COUNT{1'b0}};
    end
  end

  // Stage 2: one-cycle pop strobe and service flag; index carried for the mux.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      read_is_io_r <= 1'b0;
      active_r     <= {IO_READ_PORT_COUNT{1'b0}};
      idx2_r       <= {IW{1'b0}};
    end else begin
      read_is_io_r <= accept_s;
      active_r     <= strobe_s;
      idx2_r       <= idx_r;
    end
  end

  // Port word is taken at the same edge that ends the strobe cycle.
  always_comb begin
    port_word_s = bus.data_IO[idx2_r*WORD_WIDTH +: WORD_WIDTH];
  end

  // Stage 3: operand word toward the ALU.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      read_data_r <= {WORD_WIDTH{1'b0}};
    end else if (read_is_io_r) begin
      read_data_r <= port_word_s;
    end else begin
      read_data_r <= bus.data_RAM;
    end
  end

  assign bus.EmptyFull_masked = ef_masked_r;
  assign bus.active_IO        = active_r;
  assign bus.read_is_IO       = read_is_io_r;
  assign bus.read_data        = read_data_r;

endmodule

// File: tb/tb_io_read.sv
// tb_io_read
//   Drives directed scenarios followed by random traffic into io_read and
//   compares every output on every cycle against a history-based model of
//   the read rules, plus literal expectations for the directed scenarios.
module tb_io_read;
  localparam int W    = 36;
  localparam int A    = 10;
  localparam int C    = 4;
  localparam int BASE = 1020;
  localparam int N    = 2048;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  io_read_if #(.WORD_WIDTH(W), .ADDR_WIDTH(A), .IO_READ_PORT_COUNT(C)) bus ();

  io_read #(
    .WORD_WIDTH(W), .ADDR_WIDTH(A), .IO_READ_PORT_COUNT(C),
    .IO_READ_PORT_BASE_ADDR(BASE), .IO_READ_PORT_ADDR_WIDTH(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // Per-cycle input history (index = cycle in which the input was presented)
  logic [A-1:0]   h_addr [N];
  logic           h_re   [N];
  logic [C-1:0]   h_ef   [N];
  logic           h_rdy  [N];
  logic [C*W-1:0] h_dio  [N];
  logic [W-1:0]   h_ram  [N];
  logic           h_rst  [N];

  // Literal expectations: field 0 EmptyFull_masked, 1 active_IO, 2 read_is_IO, 3 read_data
  bit             lv   [N][4];
  logic [W-1:0]   lval [N][4];

  logic [C*W-1:0] port_words;

  function automatic logic [W-1:0] r36();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[W-1:0];
  endfunction

  function automatic bit rst_hi(int k);
    if (k < 0) return 1'b0;
    return h_rst[k];
  endfunction

  function automatic bit io_addr(int k);
    if (k < 0) return 1'b0;
    return h_re[k] && (int'(h_addr[k]) >= BASE) && (int'(h_addr[k]) < BASE + C);
  endfunction

  function automatic int pidx(int k);
    return int'(h_addr[k]) - BASE;
  endfunction

  // A read issued in cycle k pops its port iff no reset hit the two edges
  // carrying it, the port was Full in cycle k and the thread was ready in k+1.
  function automatic bit accepted(int k);
    if (!io_addr(k)) return 1'b0;
    return rst_hi(k) && rst_hi(k + 1) && h_ef[k][pidx(k)] && h_rdy[k + 1];
  endfunction

  task automatic step(input logic [A-1:0] a, input logic re, input logic [C-1:0] ef,
                      input logic rdy, input logic [W-1:0] ram, input logic rst);
    bus.addr_raw    = a;
    bus.read_enable = re;
    bus.EmptyFull   = ef;
    bus.IO_ready    = rdy;
    bus.data_IO     = port_words;
    bus.data_RAM    = ram;
    reset_n         = rst;
    h_addr[cyc] = a;   h_re[cyc]  = re;  h_ef[cyc]  = ef;  h_rdy[cyc] = rdy;
    h_dio[cyc]  = port_words;  h_ram[cyc] = ram;  h_rst[cyc] = rst;
    @(posedge clock);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic lit(int c, int f, logic [W-1:0] v);
    lv[c][f]   = 1'b1;
    lval[c][f] = v;
  endtask

  task automatic chk(string name, int t, logic [W-1:0] act, logic [W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, t, act, exp);
    end
  endtask

  // Compare process: outputs of cycle t checked mid-cycle against model and literals.
  always @(negedge clock) begin
    int t;
    logic [W-1:0] e_efm, e_act, e_ris, e_rd;
    logic [W-1:0] a_efm, a_act, a_ris, a_rd;
    t = cyc;
    if (t >= 1 && t < N) begin
      e_efm = '0; e_act = '0; e_ris = '0; e_rd = '0;
      if (rst_hi(t - 1)) begin
        e_efm[0] = io_addr(t - 1) ? h_ef[t - 1][pidx(t - 1)] : 1'b1;
      end
      if (accepted(t - 2)) begin
        e_ris[0] = 1'b1;
        e_act[pidx(t - 2)] = 1'b1;
      end
      if (rst_hi(t - 1)) begin
        if (accepted(t - 3)) e_rd = h_dio[t - 1][pidx(t - 3)*W +: W];
        else                 e_rd = h_ram[t - 1];
      end
      a_efm = '0; a_efm[0] = bus.EmptyFull_masked;
      a_act = '0; a_act[C-1:0] = bus.active_IO;
      a_ris = '0; a_ris[0] = bus.read_is_IO;
      a_rd  = bus.read_data;
      chk("model_EmptyFull_masked", t, a_efm, e_efm);
      chk("model_active_IO",        t, a_act, e_act);
      chk("model_read_is_IO",       t, a_ris, e_ris);
      chk("model_read_data",        t, a_rd,  e_rd);
      if (lv[t][0]) chk("lit_EmptyFull_masked", t, a_efm, lval[t][0]);
      if (lv[t][1]) chk("lit_active_IO",        t, a_act, lval[t][1]);
      if (lv[t][2]) chk("lit_read_is_IO",       t, a_ris, lval[t][2]);
      if (lv[t][3]) chk("lit_read_data",        t, a_rd,  lval[t][3]);
    end
  end

  initial begin
    int c;
    logic [W-1:0] w0, w1, w3;
    port_words = '0;

    // Reset for a few cycles; the first post-reset cycle must show all zeros.
    for (int i = 0; i < 3; i++) step(10'd0, 1'b0, 4'b0000, 1'b0, 36'h0, 1'b0);
    lit(cyc + 1, 0, 36'h1);
    lit(cyc, 1, 36'h0); lit(cyc, 2, 36'h0); lit(cyc, 3, 36'h0);
    step(10'd0, 1'b0, 4'b0000, 1'b0, 36'h0, 1'b1);

    // 1: port 2 full and ready
    port_words = {r36(), 36'h0DEADBEEF, r36(), r36()};
    c = cyc;
    lit(c + 1, 0, 36'h1); lit(c + 2, 1, 36'h4); lit(c + 2, 2, 36'h1);
    lit(c + 3, 3, 36'h0DEADBEEF); lit(c + 3, 1, 36'h0);
    step(10'd1022, 1'b1, 4'b0100, 1'b0, 36'h0,   1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b1, 36'h0,   1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b0, 36'h555, 1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b0, 36'h0,   1'b1);

    // 2a: port 2 empty
    c = cyc;
    lit(c + 1, 0, 36'h0); lit(c + 2, 1, 36'h0); lit(c + 2, 2, 36'h0);
    step(10'd1022, 1'b1, 4'b1011, 1'b0, 36'h0,   1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b1, 36'h0,   1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b0, 36'h0,   1'b1);
    // 2b: full but thread annulled
    c = cyc;
    lit(c + 2, 1, 36'h0); lit(c + 3, 3, 36'h555);
    step(10'd1022, 1'b1, 4'b0100, 1'b1, 36'h0,   1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b0, 36'h0,   1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b0, 36'h555, 1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b0, 36'h0,   1'b1);

    // 3: plain RAM address
    c = cyc;
    lit(c + 1, 0, 36'h1); lit(c + 2, 1, 36'h0); lit(c + 2, 2, 36'h0); lit(c + 3, 3, 36'h123);
    step(10'd100, 1'b1, 4'b1111, 1'b0, 36'h0,   1'b1);
    step(10'd0,   1'b0, 4'b1111, 1'b1, 36'h0,   1'b1);
    step(10'd0,   1'b0, 4'b1111, 1'b0, 36'h123, 1'b1);
    step(10'd0,   1'b0, 4'b0000, 1'b0, 36'h0,   1'b1);

    // 4: back-to-back reads 1020, 1021, 1023, 50
    w0 = 36'h111111111; w1 = 36'h222222222; w3 = 36'h833333333;
    port_words = {w3, 36'h044444444, w1, w0};
    c = cyc;
    lit(c + 2, 1, 36'h1); lit(c + 3, 1, 36'h2); lit(c + 4, 1, 36'h8); lit(c + 5, 1, 36'h0);
    lit(c + 3, 3, w0); lit(c + 4, 3, w1); lit(c + 5, 3, w3); lit(c + 6, 3, 36'h777);
    step(10'd1020, 1'b1, 4'b1111, 1'b1, 36'h777, 1'b1);
    step(10'd1021, 1'b1, 4'b1111, 1'b1, 36'h777, 1'b1);
    step(10'd1023, 1'b1, 4'b1111, 1'b1, 36'h777, 1'b1);
    step(10'd50,   1'b1, 4'b1111, 1'b1, 36'h777, 1'b1);
    for (int i = 0; i < 3; i++) step(10'd0, 1'b0, 4'b1111, 1'b1, 36'h777, 1'b1);

    // 5: just outside the window, and a disabled in-window read
    c = cyc;
    lit(c + 1, 0, 36'h1); lit(c + 2, 1, 36'h0); lit(c + 3, 1, 36'h0); lit(c + 4, 1, 36'h0);
    lit(c + 5, 3, 36'h999);
    step(10'd1019, 1'b1, 4'b1111, 1'b1, 36'h999, 1'b1);
    step(10'd1024 - 10'd1, 1'b0, 4'b1111, 1'b1, 36'h999, 1'b1);
    step(10'd1021, 1'b0, 4'b1111, 1'b1, 36'h999, 1'b1);
    for (int i = 0; i < 3; i++) step(10'd0, 1'b0, 4'b1111, 1'b1, 36'h999, 1'b1);

    // 6: reset during cycle 1 drops the read; next read completes normally
    port_words = {r36(), 36'h0DEADBEEF, r36(), 36'h0CAFEF00D};
    c = cyc;
    lit(c + 2, 0, 36'h0); lit(c + 2, 1, 36'h0); lit(c + 2, 2, 36'h0); lit(c + 2, 3, 36'h0);
    lit(c + 3, 1, 36'h0); lit(c + 3, 0, 36'h1);
    lit(c + 4, 1, 36'h1); lit(c + 4, 2, 36'h1); lit(c + 5, 3, 36'h0CAFEF00D);
    step(10'd1022, 1'b1, 4'b0100, 1'b0, 36'h0, 1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b1, 36'h0, 1'b0);
    step(10'd1020, 1'b1, 4'b0001, 1'b0, 36'h0, 1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b1, 36'h0, 1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b0, 36'h0, 1'b1);
    step(10'd0,    1'b0, 4'b0000, 1'b0, 36'h0, 1'b1);

    // Random traffic with window-biased addresses and occasional resets
    for (int i = 0; i < 700; i++) begin
      logic [A-1:0] a;
      for (int p = 0; p < C; p++) port_words[p*W +: W] = r36();
      if ($urandom_range(0, 9) < 6) a = A'($urandom_range(1018, 1023));
      else                          a = A'($urandom());
      step(a, ($urandom_range(0, 7) != 0), C'($urandom()), ($urandom_range(0, 3) != 0),
           r36(), ($urandom_range(0, 39) != 0));
    end
    for (int i = 0; i < 4; i++) step(10'd0, 1'b0, 4'b0000, 1'b0, 36'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
